// File: rtl/sys_row_injector.sv
// rtl/sys_row_injector.sv - west-edge activation injector and psum capture for one systolic PE row (optional SYS_INJ_PERF_EN)
module sys_row_injector #(
    parameter int I_WIDTH    = 8,
    parameter int P_WIDTH    = 20,
    parameter int CTRL_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int VEC_LEN    = 16,
    parameter int PSUM_LAT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [I_WIDTH-1:0]    s_iact_data,
    input  logic                  s_iact_valid,
    output logic                  s_iact_ready,
    output logic [CTRL_WIDTH-1:0] sys_ctrl_out,
    output logic [I_WIDTH-1:0]    sys_iact_out,
    input  logic [P_WIDTH-1:0]    sys_psum_in,
    output logic [P_WIDTH-1:0]    m_psum_data,
    output logic                  m_psum_valid,
    input  logic                  m_psum_ready,
`ifdef SYS_INJ_PERF_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam int LW = $clog2(PSUM_LAT + 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(VEC_LEN - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(PSUM_LAT);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [I_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [OW-1:0]     occ;
    logic [CW-1:0]     cnt;
    logic [LW-1:0]     lat;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              sample;
    logic              bubble;
    logic              hold_stall;

    assign fifo_empty   = (occ == '0);
    assign s_iact_ready = (occ != OCC_FULL);
    assign push         = s_iact_valid && s_iact_ready;
    assign busy         = (state != IDLE);
    // The first pop of a vector is also its last only when a vector is one word long.
    assign last_pop     = (state == IDLE) ? (VEC_LEN == 1) : (cnt == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = last_pop ? DRAIN : STREAM;
            STREAM:  if (!fifo_empty && last_pop) state_next = DRAIN;
            DRAIN:   if (lat == LW'(1)) state_next = HOLD;
            HOLD:    if (m_psum_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: pop strobe, psum sample strobe and stall qualifiers
    always_comb begin
        pop        = 1'b0;
        sample     = 1'b0;
        bubble     = 1'b0;
        hold_stall = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            STREAM: begin
                pop    = !fifo_empty;
                bubble = fifo_empty;
            end
            DRAIN:   sample = (lat == LW'(1));
            HOLD:    hold_stall = !m_psum_ready;
            default: ;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_iact_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves occupancy alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      occ <= occ + OW'(1);
            else if (pop && !push) occ <= occ - OW'(1);
        end
    end

    // Systolic drive into the first router: head word with strobe on pop, zeros otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_iact_out <= '0;
            sys_ctrl_out <= '0;
        end else begin
            sys_iact_out <= pop ? mem[rd_ptr] : '0;
            sys_ctrl_out <= CTRL_WIDTH'(pop);
        end
    end

    // Element count within the vector and the drain latency countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            lat <= '0;
        end else begin
            if (pop) cnt <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
            if (pop && last_pop)      lat <= LAT_INIT;
            else if (state == DRAIN)  lat <= lat - LW'(1);
        end
    end

    // Psum capture from the row tail, held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_psum_data  <= '0;
            m_psum_valid <= 1'b0;
        end else if (sample) begin
            m_psum_data  <= sys_psum_in;
            m_psum_valid <= 1'b1;
        end else if (state == HOLD && m_psum_ready) begin
            m_psum_valid <= 1'b0;
        end
    end

`ifdef SYS_INJ_PERF_EN
    // Saturating count of mid-vector bubbles and back-pressured hold cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((bubble || hold_stall) && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = bubble ^ hold_stall;
`endif

endmodule

// File: tb/tb_sys_row_injector.sv
// tb/tb_sys_row_injector.sv - self-checking bench for sys_row_injector
module tb_sys_row_injector;

    localparam int IW = 8;
    localparam int PW = 20;
    localparam int DEPTH = 4;
    localparam int VLEN = 4;
    localparam int PLAT = 3;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] s_iact_data;
    logic          s_iact_valid;
    logic          s_iact_ready;
    logic [0:0]    sys_ctrl_out;
    logic [IW-1:0] sys_iact_out;
    logic [PW-1:0] sys_psum_in;
    logic [PW-1:0] m_psum_data;
    logic          m_psum_valid;
    logic          m_psum_ready;
    logic          busy;
`ifdef SYS_INJ_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    sys_row_injector #(
        .I_WIDTH(IW), .P_WIDTH(PW), .CTRL_WIDTH(1),
        .DEPTH(DEPTH), .VEC_LEN(VLEN), .PSUM_LAT(PLAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_iact_data(s_iact_data), .s_iact_valid(s_iact_valid), .s_iact_ready(s_iact_ready),
        .sys_ctrl_out(sys_ctrl_out), .sys_iact_out(sys_iact_out), .sys_psum_in(sys_psum_in),
        .m_psum_data(m_psum_data), .m_psum_valid(m_psum_valid), .m_psum_ready(m_psum_ready),
`ifdef SYS_INJ_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int strobes = 0;

    // Reference: the FIFO is a queue; a vector is described by how many words it has sent,
    // how many edges remain before the psum sample, and whether a psum is being offered.
    logic [IW-1:0] mq[$];
    int            sent;
    int            lat_left;
    bit            holding;
    bit            e_valid;
    logic [PW-1:0] e_data;
    bit            e_ctrl;
    logic [IW-1:0] e_iact;
    int unsigned   e_stall;
    logic [IW-1:0] pend[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sent = 0; lat_left = 0; holding = 0;
        e_valid = 0; e_data = '0; e_ctrl = 0; e_iact = '0; e_stall = 0;
    endtask

    task automatic model_step();
        bit can_push;
        can_push = s_iact_valid && (mq.size() != DEPTH);
        e_ctrl = 0;
        e_iact = '0;
        if (holding) begin
            if (!m_psum_ready) e_stall++;
            else begin
                holding = 0; e_valid = 0; sent = 0;
            end
        end else if (sent == VLEN) begin
            if (lat_left == 1) begin
                e_valid = 1; e_data = sys_psum_in; holding = 1;
            end
            lat_left--;
        end else if (mq.size() > 0) begin
            e_iact = mq.pop_front();
            e_ctrl = 1;
            sent++;
            if (sent == VLEN) lat_left = PLAT;
        end else if (sent > 0) begin
            e_stall++;
        end
        if (can_push) mq.push_back(s_iact_data);
    endtask

    task automatic compare_all();
        check("ready", 32'(s_iact_ready), 32'(mq.size() != DEPTH));
        check("ctrl", 32'(sys_ctrl_out), 32'(e_ctrl));
        check("iact", 32'(sys_iact_out), 32'(e_iact));
        check("psum_valid", 32'(m_psum_valid), 32'(e_valid));
        check("psum_data", 32'(m_psum_data), 32'(e_data));
        check("busy", 32'(busy), 32'(holding || sent > 0));
`ifdef SYS_INJ_PERF_EN
        check("stall_cnt", stall_cnt, e_stall);
`endif
        if (sys_ctrl_out[0]) strobes++;
    endtask

    // One clock: producer handshake taken from the DUT's ready before the edge
    task automatic cycle(output bit acc);
        acc = s_iact_valid && s_iact_ready;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            s_iact_valid = (pend.size() > 0);
            s_iact_data  = (pend.size() > 0) ? pend[0] : '0;
            cycle(acc);
            if (acc) void'(pend.pop_front());
        end
        s_iact_valid = 1'b0;
    endtask

    typedef struct {
        bit            v;
        logic [IW-1:0] d;
        bit            ctrl;
        logic [IW-1:0] iact;
        bit            pv;
        bit            bsy;
    } vec_t;

    initial begin
        vec_t tbl[10];
        bit acc;
        int base;
`ifdef SYS_INJ_PERF_EN
        int unsigned st0;
`endif
        tbl[0] = '{1, 8'h11, 0, 8'h00, 0, 0};
        tbl[1] = '{1, 8'h22, 1, 8'h11, 0, 1};
        tbl[2] = '{1, 8'h33, 1, 8'h22, 0, 1};
        tbl[3] = '{1, 8'h44, 1, 8'h33, 0, 1};
        tbl[4] = '{0, 8'h00, 1, 8'h44, 0, 1};
        tbl[5] = '{0, 8'h00, 0, 8'h00, 0, 1};
        tbl[6] = '{0, 8'h00, 0, 8'h00, 0, 1};
        tbl[7] = '{0, 8'h00, 0, 8'h00, 1, 1};
        tbl[8] = '{0, 8'h00, 0, 8'h00, 0, 0};
        tbl[9] = '{0, 8'h00, 0, 8'h00, 0, 0};

        rst_n = 0; s_iact_valid = 0; s_iact_data = '0;
        sys_psum_in = 20'h12345; m_psum_ready = 1;
        model_reset();
        cycle(acc);
        cycle(acc);
        rst_n = 1;

        // Back-to-back vector
        for (int i = 0; i < 10; i++) begin
            s_iact_valid = tbl[i].v;
            s_iact_data  = tbl[i].d;
            cycle(acc);
            check("tbl_ctrl", 32'(sys_ctrl_out), 32'(tbl[i].ctrl));
            check("tbl_iact", 32'(sys_iact_out), 32'(tbl[i].iact));
            check("tbl_valid", 32'(m_psum_valid), 32'(tbl[i].pv));
            check("tbl_busy", 32'(busy), 32'(tbl[i].bsy));
            if (tbl[i].pv) check("tbl_psum", 32'(m_psum_data), 32'h12345);
        end

        // Bubble: two idle input cycles after the 2nd word
`ifdef SYS_INJ_PERF_EN
        st0 = stall_cnt;
`endif
        strobes = 0;
        pend = '{8'hA1, 8'hA2};
        run(2);
        run(2);
        pend = '{8'hA3, 8'hA4};
        run(12);
        check("bubble_strobes", 32'(strobes), 32'd4);
        check("bubble_idle", 32'(busy), 32'd0);
`ifdef SYS_INJ_PERF_EN
        check("bubble_stall", stall_cnt - st0, 32'd2);
`endif

        // Psum hold for 5 cycles
        sys_psum_in = 20'hBEEF1;
        m_psum_ready = 0;
        pend = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 20 && !m_psum_valid; i++) run(1);
        check("hold_rise", 32'(m_psum_valid), 32'd1);
`ifdef SYS_INJ_PERF_EN
        st0 = stall_cnt;
`endif
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            sys_psum_in = PW'($urandom);
            run(1);
            check("hold_valid", 32'(m_psum_valid), 32'd1);
            check("hold_data", 32'(m_psum_data), 32'hBEEF1);
            check("hold_busy", 32'(busy), 32'd1);
        end
        check("hold_no_strobe", 32'(strobes), 32'd0);
        m_psum_ready = 1;
        run(1);
        check("hold_release", 32'(busy), 32'd0);
`ifdef SYS_INJ_PERF_EN
        check("hold_stall", stall_cnt - st0, 32'd5);
`endif

        // Backpressure: psum consumer stalled while 12 words are offered
        m_psum_ready = 0;
        strobes = 0;
        pend.delete();
        for (int i = 0; i < 12; i++) pend.push_back(IW'(8'h40 + i));
        run(20);
        check("bp_ready_low", 32'(s_iact_ready), 32'd0);
        check("bp_pending", 32'(pend.size()), 32'd4);
        m_psum_ready = 1;
        run(40);
        check("bp_strobes", 32'(strobes), 32'd12);
        check("bp_drained", 32'(pend.size()), 32'd0);
        check("bp_idle", 32'(busy), 32'd0);

        // Reset mid-stream after the 2nd strobe
        strobes = 0;
        pend = '{8'h91, 8'h92, 8'h93, 8'h94};
        for (int i = 0; i < 10 && strobes < 2; i++) run(1);
        check("rst_pre_strobes", 32'(strobes), 32'd2);
        #2 rst_n = 0;
        #1;
        check("rst_ctrl", 32'(sys_ctrl_out), 32'd0);
        check("rst_iact", 32'(sys_iact_out), 32'd0);
        check("rst_valid", 32'(m_psum_valid), 32'd0);
        check("rst_data", 32'(m_psum_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_iact_ready), 32'd1);
        model_reset();
        pend.delete();
        cycle(acc);
        rst_n = 1;
        strobes = 0;
        pend = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run(14);
        check("rst_fresh_strobes", 32'(strobes), 32'd4);

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            s_iact_valid = ($urandom_range(0, 9) < 7);
            s_iact_data  = IW'($urandom);
            m_psum_ready = ($urandom_range(0, 9) < 6);
            sys_psum_in  = PW'($urandom);
            cycle(acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
